// File: rtl/l2_sched_pkg.sv
// rtl/l2_sched_pkg.sv - shared types and helpers for the L2 crossbar address-phase scheduler
package l2_sched_pkg;

    typedef enum logic [1:0] {
        TGT_HND = 2'd0,
        TGT_PKT = 2'd1,
        TGT_ERR = 2'd2
    } tgt_e;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic REQ_PE  = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    // The reserved encoding routes to the error slave, so it is folded into TGT_ERR.
    function automatic tgt_e to_tgt(input logic [1:0] raw);
        return (raw == 2'd0) ? TGT_HND : (raw == 2'd1) ? TGT_PKT : TGT_ERR;
    endfunction

endpackage

// File: rtl/l2_credit_cnt.sv
// rtl/l2_credit_cnt.sv - saturating outstanding-transaction counter with full flag and underflow pulse
module l2_credit_cnt #(
    parameter int MaxCount = 16,
    parameter int Width    = $clog2(MaxCount + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [Width-1:0] cnt_o,
    output logic             full_o,
    output logic             uflow_o
);
    localparam logic [Width-1:0] MaxVal = Width'(MaxCount);
    localparam logic [Width-1:0] One    = Width'(1);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        uflow_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (cnt_q != MaxVal) cnt_d = cnt_q + One;
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) uflow_o = 1'b1;
            else             cnt_d   = cnt_q - One;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign full_o = (cnt_q >= MaxVal);

endmodule

// File: rtl/l2_xbar_txn_sched.sv
// rtl/l2_xbar_txn_sched.sv - weighted round-robin PE/DMA address-phase gate with per-target credits
module l2_xbar_txn_sched
    import l2_sched_pkg::*;
#(
    parameter int MaxOutstanding = 16,
    parameter int PeWeight       = 1,
    parameter int DmaWeight      = 4,
    parameter int CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pe_valid_i,
    input  logic [1:0]          pe_tgt_i,
    output logic                pe_ready_o,
    output logic                pe_valid_o,
    input  logic                pe_ready_i,
    input  logic                dma_valid_i,
    input  logic [1:0]          dma_tgt_i,
    output logic                dma_ready_o,
    output logic                dma_valid_o,
    input  logic                dma_ready_i,
    input  logic [1:0]          cpl_i,
    output logic [CntWidth-1:0] hnd_cnt_o,
    output logic [CntWidth-1:0] pkt_cnt_o,
    output logic                cnt_err_o
);
    localparam logic [3:0] PeW  = 4'(PeWeight);
    localparam logic [3:0] DmaW = 4'(DmaWeight);

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic [3:0] weight_q, weight_d, weight_eff;
    logic       out_en_q, out_en, cnt_err_q;
    logic [1:0] req, rdy, elig, gnt, hs;
    logic       gnt_idx;
    tgt_e       tgt [2];
    tgt_e       hs_tgt;
    logic       hnd_full, pkt_full, hnd_uflow, pkt_uflow;

    function automatic logic [3:0] reload(input logic side);
        return (side == REQ_DMA) ? DmaW : PeW;
    endfunction

    assign req            = {dma_valid_i, pe_valid_i};
    assign rdy            = {dma_ready_i, pe_ready_i};
    assign tgt[REQ_PE]    = to_tgt(pe_tgt_i);
    assign tgt[REQ_DMA]   = to_tgt(dma_tgt_i);
    // Grants stay off through reset and the cycle after so credits settle before traffic.
    assign out_en         = out_en_q & ~rst_i;

    always_comb begin
        elig = '0;
        for (int i = 0; i < 2; i++) begin
            elig[i] = req[i] & ((tgt[i] == TGT_ERR) |
                                ((tgt[i] == TGT_HND) & ~hnd_full) |
                                ((tgt[i] == TGT_PKT) & ~pkt_full));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ARB;
            owner_q   <= REQ_DMA;
            weight_q  <= DmaW;
            out_en_q  <= 1'b0;
            cnt_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            weight_q  <= weight_d;
            out_en_q  <= 1'b1;
            cnt_err_q <= cnt_err_q | hnd_uflow | pkt_uflow;
        end
    end

    // A held grant ignores credits: it was credit-checked when first issued.
    always_comb begin
        gnt = '0;
        if (out_en) begin
            if (state_q == HOLD)                        gnt[owner_q]  = 1'b1;
            else if (elig[owner_q] && weight_q != '0)   gnt[owner_q]  = 1'b1;
            else if (elig[~owner_q])                    gnt[~owner_q] = 1'b1;
        end
    end

    assign hs         = req & rdy & gnt;
    assign gnt_idx    = gnt[REQ_DMA];
    assign hs_tgt     = tgt[gnt_idx];
    assign weight_eff = (gnt_idx != owner_q) ? reload(gnt_idx) : weight_q;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        weight_d = weight_q;
        if (|gnt) begin
            owner_d  = gnt_idx;
            weight_d = weight_eff;
            if (|hs) begin
                state_d = ARB;
                if (weight_eff <= 4'd1) begin
                    if (req[~gnt_idx]) begin
                        owner_d  = ~gnt_idx;
                        weight_d = reload(~gnt_idx);
                    end else begin
                        weight_d = reload(gnt_idx);
                    end
                end else begin
                    weight_d = weight_eff - 4'd1;
                end
            end else if (state_q == HOLD && !req[gnt_idx]) begin
                state_d = ARB;
            end else begin
                state_d = HOLD;
            end
        end
    end

    l2_credit_cnt #(.MaxCount(MaxOutstanding), .Width(CntWidth)) u_hnd_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   ((|hs) && (hs_tgt == TGT_HND)),
        .dec_i   (cpl_i[0]),
        .cnt_o   (hnd_cnt_o),
        .full_o  (hnd_full),
        .uflow_o (hnd_uflow)
    );

    l2_credit_cnt #(.MaxCount(MaxOutstanding), .Width(CntWidth)) u_pkt_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   ((|hs) && (hs_tgt == TGT_PKT)),
        .dec_i   (cpl_i[1]),
        .cnt_o   (pkt_cnt_o),
        .full_o  (pkt_full),
        .uflow_o (pkt_uflow)
    );

    assign pe_valid_o  = pe_valid_i  & gnt[REQ_PE];
    assign pe_ready_o  = pe_ready_i  & gnt[REQ_PE];
    assign dma_valid_o = dma_valid_i & gnt[REQ_DMA];
    assign dma_ready_o = dma_ready_i & gnt[REQ_DMA];
    assign cnt_err_o   = cnt_err_q;

endmodule

// File: tb/tb_l2_xbar_txn_sched.sv
// tb/tb_l2_xbar_txn_sched.sv - self-checking bench for l2_xbar_txn_sched
module tb_l2_xbar_txn_sched;
    localparam int MAXO = 4;
    localparam int PEW  = 1;
    localparam int DMAW = 4;
    localparam int CW   = $clog2(MAXO + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          pe_valid_i, pe_ready_i, pe_ready_o, pe_valid_o;
    logic [1:0]    pe_tgt_i;
    logic          dma_valid_i, dma_ready_i, dma_ready_o, dma_valid_o;
    logic [1:0]    dma_tgt_i;
    logic [1:0]    cpl_i;
    logic [CW-1:0] hnd_cnt_o, pkt_cnt_o;
    logic          cnt_err_o;

    always #5 clk = ~clk;

    l2_xbar_txn_sched #(.MaxOutstanding(MAXO), .PeWeight(PEW), .DmaWeight(DMAW)) dut (
        .clk_i(clk), .rst_i(rst),
        .pe_valid_i(pe_valid_i), .pe_tgt_i(pe_tgt_i), .pe_ready_o(pe_ready_o),
        .pe_valid_o(pe_valid_o), .pe_ready_i(pe_ready_i),
        .dma_valid_i(dma_valid_i), .dma_tgt_i(dma_tgt_i), .dma_ready_o(dma_ready_o),
        .dma_valid_o(dma_valid_o), .dma_ready_i(dma_ready_i),
        .cpl_i(cpl_i), .hnd_cnt_o(hnd_cnt_o), .pkt_cnt_o(pkt_cnt_o), .cnt_err_o(cnt_err_o)
    );

    a_pe_stable: assert property (@(posedge clk) disable iff (rst)
        (pe_valid_o && !pe_ready_i) |=> pe_valid_i);
    a_dma_stable: assert property (@(posedge clk) disable iff (rst)
        (dma_valid_o && !dma_ready_i) |=> dma_valid_i);

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: side 0 = PE, side 1 = DMA; streak counts grants taken in the current turn.
    int m_cnt [2] = '{0, 0};
    bit m_err = 0, m_hold = 0, m_en = 0;
    int m_lock = 0, m_owner = 1, m_streak = 0;

    logic          s_pvo, s_pro, s_dvo, s_dro, s_err;
    logic [CW-1:0] s_hnd, s_pkt;

    function automatic int wt(int side);
        return (side == 1) ? DMAW : PEW;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [1:0] pt, input logic pr,
                         input logic dv, input logic [1:0] dt, input logic dr,
                         input logic [1:0] cpl);
        pe_valid_i = pv;  pe_tgt_i = pt;  pe_ready_i = pr;
        dma_valid_i = dv; dma_tgt_i = dt; dma_ready_i = dr;
        cpl_i = cpl;
    endtask

    task automatic step(input string tag);
        int v [2];
        int r [2];
        int t [2];
        int elig [2];
        int g, n;
        bit hs;
        @(negedge clk);
        v[0] = int'(pe_valid_i);  r[0] = int'(pe_ready_i);  t[0] = int'(pe_tgt_i);
        v[1] = int'(dma_valid_i); r[1] = int'(dma_ready_i); t[1] = int'(dma_tgt_i);
        for (int i = 0; i < 2; i++)
            elig[i] = (v[i] != 0 && (t[i] >= 2 || m_cnt[t[i]] < MAXO)) ? 1 : 0;
        g = -1;
        if (!rst && m_en) begin
            if (m_hold) g = m_lock;
            else if (elig[m_owner] != 0 && m_streak < wt(m_owner)) g = m_owner;
            else if (elig[1 - m_owner] != 0) g = 1 - m_owner;
        end
        s_pvo = pe_valid_o; s_pro = pe_ready_o; s_dvo = dma_valid_o; s_dro = dma_ready_o;
        s_hnd = hnd_cnt_o;  s_pkt = pkt_cnt_o;  s_err = cnt_err_o;
        check({tag, "_pe_valid_o"},  s_pvo, (g == 0 && v[0] != 0) ? 1 : 0);
        check({tag, "_pe_ready_o"},  s_pro, (g == 0 && r[0] != 0) ? 1 : 0);
        check({tag, "_dma_valid_o"}, s_dvo, (g == 1 && v[1] != 0) ? 1 : 0);
        check({tag, "_dma_ready_o"}, s_dro, (g == 1 && r[1] != 0) ? 1 : 0);
        check({tag, "_hnd_cnt"},     s_hnd, m_cnt[0]);
        check({tag, "_pkt_cnt"},     s_pkt, m_cnt[1]);
        check({tag, "_cnt_err"},     s_err, m_err);
        if (rst) begin
            m_cnt = '{0, 0}; m_err = 0; m_hold = 0; m_en = 0; m_owner = 1; m_streak = 0;
        end else begin
            m_en = 1;
            hs = (g >= 0) && v[g] != 0 && r[g] != 0;
            if (g >= 0) begin
                if (g != m_owner) begin
                    m_owner = g;
                    m_streak = 0;
                end
                if (hs) begin
                    m_hold = 0;
                    m_streak++;
                    if (m_streak >= wt(g)) begin
                        m_streak = 0;
                        if (v[1 - g] != 0) m_owner = 1 - g;
                    end
                end else if (!m_hold) begin
                    m_hold = 1;
                    m_lock = g;
                end else if (v[g] == 0) begin
                    m_hold = 0;
                end
            end
            for (int k = 0; k < 2; k++) begin
                n = m_cnt[k] + ((hs && t[g] == k) ? 1 : 0) - int'(cpl_i[k]);
                if (n < 0) begin
                    n = 0;
                    m_err = 1;
                end
                m_cnt[k] = n;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        step("reset");
        rst = 1'b0;
    endtask

    typedef struct {
        logic pv; logic [1:0] pt; logic pr;
        logic dv; logic [1:0] dt; logic dr;
        logic [1:0] cpl;
        logic e_pvo; logic e_dvo; int e_hnd; int e_pkt; logic e_err;
    } vec_t;

    function automatic vec_t mk(logic pv, logic [1:0] pt, logic pr, logic dv, logic [1:0] dt,
                                logic dr, logic [1:0] cpl, logic epv, logic edv,
                                int eh, int ep, logic ee);
        vec_t x;
        x.pv = pv; x.pt = pt; x.pr = pr; x.dv = dv; x.dt = dt; x.dr = dr; x.cpl = cpl;
        x.e_pvo = epv; x.e_dvo = edv; x.e_hnd = eh; x.e_pkt = ep; x.e_err = ee;
        return x;
    endfunction

    vec_t tbl [27];
    logic wrr_dma [10];

    initial begin
        tbl[0]  = mk(1,0,1, 0,0,0, 2'b00, 0,0, 0,0,0);
        tbl[1]  = mk(1,0,1, 0,0,0, 2'b00, 1,0, 0,0,0);
        tbl[2]  = mk(0,0,0, 0,0,0, 2'b00, 0,0, 1,0,0);
        tbl[3]  = mk(0,0,0, 0,0,0, 2'b01, 0,0, 1,0,0);
        tbl[4]  = mk(0,0,0, 0,0,0, 2'b00, 0,0, 0,0,0);
        tbl[5]  = mk(0,0,0, 0,0,0, 2'b01, 0,0, 0,0,0);
        tbl[6]  = mk(0,0,0, 0,0,0, 2'b00, 0,0, 0,0,1);
        tbl[7]  = mk(0,0,0, 0,0,0, 2'b00, 0,0, 0,0,1);
        tbl[8]  = mk(0,0,0, 1,0,1, 2'b00, 0,1, 0,0,1);
        tbl[9]  = mk(0,0,0, 1,0,1, 2'b00, 0,1, 1,0,1);
        tbl[10] = mk(0,0,0, 1,0,1, 2'b00, 0,1, 2,0,1);
        tbl[11] = mk(0,0,0, 1,0,1, 2'b00, 0,1, 3,0,1);
        tbl[12] = mk(0,0,0, 1,0,1, 2'b00, 0,0, 4,0,1);
        tbl[13] = mk(0,0,0, 1,0,1, 2'b01, 0,0, 4,0,1);
        tbl[14] = mk(0,0,0, 1,0,1, 2'b00, 0,1, 3,0,1);
        tbl[15] = mk(0,0,0, 0,0,0, 2'b00, 0,0, 4,0,1);
        tbl[16] = mk(1,1,1, 0,0,0, 2'b00, 1,0, 4,0,1);
        tbl[17] = mk(1,1,1, 0,0,0, 2'b00, 1,0, 4,1,1);
        tbl[18] = mk(1,1,1, 0,0,0, 2'b00, 1,0, 4,2,1);
        tbl[19] = mk(1,1,1, 0,0,0, 2'b00, 1,0, 4,3,1);
        tbl[20] = mk(1,1,1, 0,0,0, 2'b00, 0,0, 4,4,1);
        tbl[21] = mk(1,2,1, 1,3,1, 2'b00, 1,0, 4,4,1);
        tbl[22] = mk(1,2,1, 1,3,1, 2'b00, 0,1, 4,4,1);
        tbl[23] = mk(0,0,0, 0,0,0, 2'b00, 0,0, 4,4,1);
        tbl[24] = mk(0,0,0, 0,0,0, 2'b10, 0,0, 4,4,1);
        tbl[25] = mk(1,1,1, 0,0,0, 2'b10, 1,0, 4,3,1);
        tbl[26] = mk(0,0,0, 0,0,0, 2'b00, 0,0, 4,3,1);
        wrr_dma = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].pv, tbl[i].pt, tbl[i].pr, tbl[i].dv, tbl[i].dt, tbl[i].dr, tbl[i].cpl);
            step("tbl");
            check($sformatf("tbl%0d_pe_valid_o", i),  s_pvo, tbl[i].e_pvo);
            check($sformatf("tbl%0d_dma_valid_o", i), s_dvo, tbl[i].e_dvo);
            check($sformatf("tbl%0d_hnd_cnt", i),     s_hnd, tbl[i].e_hnd);
            check($sformatf("tbl%0d_pkt_cnt", i),     s_pkt, tbl[i].e_pkt);
            check($sformatf("tbl%0d_cnt_err", i),     s_err, tbl[i].e_err);
        end

        // Weighted round-robin with both sides always requesting the error target.
        do_reset();
        step("gap");
        drive(1, 2, 1, 1, 2, 1, 2'b00);
        for (int i = 0; i < 10; i++) begin
            step("wrr");
            check($sformatf("wrr%0d_dma", i), s_dvo, wrr_dma[i]);
            check($sformatf("wrr%0d_pe", i),  s_pvo, !wrr_dma[i]);
        end

        // PE held while stalled; DMA must wait until the PE handshake.
        do_reset();
        step("gap");
        drive(1, 0, 0, 0, 0, 0, 2'b00);
        step("hold");
        check("hold_first_pe_valid", s_pvo, 1'b1);
        check("hold_first_pe_ready", s_pro, 1'b0);
        drive(1, 0, 0, 1, 0, 1, 2'b00);
        for (int i = 0; i < 4; i++) begin
            step("hold");
            check($sformatf("hold%0d_pe_valid", i),  s_pvo, 1'b1);
            check($sformatf("hold%0d_dma_valid", i), s_dvo, 1'b0);
        end
        drive(1, 0, 1, 1, 0, 1, 2'b00);
        step("hold");
        check("hold_rel_pe_ready", s_pro, 1'b1);
        check("hold_rel_dma_valid", s_dvo, 1'b0);
        drive(0, 0, 0, 1, 0, 1, 2'b00);
        step("hold");
        check("hold_after_dma_valid", s_dvo, 1'b1);

        // Reset arriving while a grant is held drops it at once.
        drive(1, 1, 0, 0, 0, 0, 2'b00);
        step("rsthold");
        check("rsthold_pre_pe_valid", s_pvo, 1'b1);
        rst = 1'b1;
        step("rsthold");
        check("rsthold_in_reset_pe_valid", s_pvo, 1'b0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 2'b00);
        step("gap");

        // Random traffic against the model, keeping held requests stable.
        for (int i = 0; i < 3000; i++) begin
            logic pv, pr, dv, dr;
            logic [1:0] pt, dt, cpl;
            pv = ($urandom_range(0, 3) != 0);
            pt = 2'($urandom_range(0, 3));
            pr = ($urandom_range(0, 2) != 0);
            dv = ($urandom_range(0, 3) != 0);
            dt = 2'($urandom_range(0, 3));
            dr = ($urandom_range(0, 2) != 0);
            cpl = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            if (m_hold && m_lock == 0) begin pv = 1'b1; pt = pe_tgt_i; end
            if (m_hold && m_lock == 1) begin dv = 1'b1; dt = dma_tgt_i; end
            drive(pv, pt, pr, dv, dt, dr, cpl);
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
